// File: rtl/thread_pkg.sv
// Shared thread/PC definitions for the barrel-threaded front end.
// Fetch-address packing is reused by decode and EX.
package thread_pkg;

    localparam int unsigned NUM_THREADS_DEF = 4;
    localparam int unsigned PC_W_DEF        = 7;

    function automatic int unsigned tid_w_of(input int unsigned num_threads);
        return (num_threads > 1) ? int'($clog2(num_threads)) : 1;
    endfunction

    // {tid, pc} as a flat address; callers truncate to TID_W+PC_W.
    function automatic logic [31:0] pack_fetch_addr(input logic [31:0] tid,
                                                    input logic [31:0] pc,
                                                    input int unsigned pc_w);
        return (tid << pc_w) | pc;
    endfunction

endpackage

// File: rtl/thread_pc_sched_if.sv
// Fetch-control bundle between the pipeline (master) and the PC scheduler (slave).
interface thread_pc_sched_if #(
    parameter int unsigned NUM_THREADS = thread_pkg::NUM_THREADS_DEF,
    parameter int unsigned PC_W        = thread_pkg::PC_W_DEF
);
    localparam int unsigned TID_W = thread_pkg::tid_w_of(NUM_THREADS);

    logic                   advance;
    logic                   pc_reset_pulse;
    logic [NUM_THREADS-1:0] thread_enable;
    logic                   ex_branch_taken;
    logic [TID_W+PC_W-1:0]  ex_branch_target;
    logic                   ex_halt;
    logic [TID_W-1:0]       ex_thread_id;

    logic [TID_W+PC_W-1:0]  pc_target;
    logic [TID_W-1:0]       thread_id;
    logic                   thread_valid;
    logic [NUM_THREADS-1:0] halted;
    logic                   all_idle;

    modport master (
        output advance, pc_reset_pulse, thread_enable,
               ex_branch_taken, ex_branch_target, ex_halt, ex_thread_id,
        input  pc_target, thread_id, thread_valid, halted, all_idle
    );

    modport slave (
        input  advance, pc_reset_pulse, thread_enable,
               ex_branch_taken, ex_branch_target, ex_halt, ex_thread_id,
        output pc_target, thread_id, thread_valid, halted, all_idle
    );

endinterface

// File: rtl/rr_next_active.sv
// Round-robin successor: first set mask bit strictly after cur (wrapping),
// cur itself when it is the only set bit.
module rr_next_active #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [IDX_W-1:0] cur,
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] nxt,
    output logic             found
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;

    // Rotate so bit 0 is cur+1, priority-encode, then unrotate.
    always_comb begin
        dbl = {mask, mask};
        rot = N'(dbl >> (32'(cur) + 32'd1));
        off = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        nxt   = cur + off + IDX_W'(1);
        found = |mask;
    end

endmodule

// File: rtl/thread_pc_sched.sv
// Per-thread PC bank and round-robin thread scheduler for barrel-threaded fetch.
// Outputs are combinational from state so the fetch address has zero latency.
module thread_pc_sched
    import thread_pkg::*;
#(
    parameter int unsigned     NUM_THREADS = NUM_THREADS_DEF,
    parameter int unsigned     PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    thread_pc_sched_if.slave    bus
);

    localparam int unsigned TID_W = tid_w_of(NUM_THREADS);

    logic [PC_W-1:0]        pc_q [NUM_THREADS];
    logic [PC_W-1:0]        pc_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] halted_q, halted_d;
    logic [TID_W-1:0]       cur_q, cur_d;

    logic [NUM_THREADS-1:0] active_cur;
    logic [NUM_THREADS-1:0] active_next;
    logic [TID_W-1:0]       rr_nxt;
    logic                   rr_found;
    logic                   unused_tgt_hi;

    assign unused_tgt_hi = ^bus.ex_branch_target[TID_W+PC_W-1:PC_W];

    always_comb begin
        halted_d = halted_q;
        if (bus.pc_reset_pulse) begin
            halted_d = '0;
        end else if (bus.ex_halt) begin
            halted_d[bus.ex_thread_id] = 1'b1;
        end
        active_cur  = bus.thread_enable & ~halted_q;
        active_next = bus.thread_enable & ~halted_d;
    end

    rr_next_active #(
        .N     (NUM_THREADS),
        .IDX_W (TID_W)
    ) u_rr (
        .cur   (cur_q),
        .mask  (active_next),
        .nxt   (rr_nxt),
        .found (rr_found)
    );

    // Redirect is applied after the increment so it always wins.
    always_comb begin
        pc_d  = pc_q;
        cur_d = cur_q;
        if (bus.pc_reset_pulse) begin
            for (int t = 0; t < int'(NUM_THREADS); t++) pc_d[t] = RESET_PC;
            cur_d = '0;
        end else begin
            if (bus.advance && active_cur[cur_q]) begin
                pc_d[cur_q] = pc_q[cur_q] + PC_W'(1);
            end
            if (bus.ex_branch_taken) begin
                pc_d[bus.ex_thread_id] = bus.ex_branch_target[PC_W-1:0];
            end
            if (bus.advance && rr_found) begin
                cur_d = rr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < int'(NUM_THREADS); t++) pc_q[t] <= RESET_PC;
            halted_q <= '0;
            cur_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            cur_q    <= cur_d;
        end
    end

    assign bus.pc_target    = (TID_W+PC_W)'(pack_fetch_addr(32'(cur_q), 32'(pc_q[cur_q]), PC_W));
    assign bus.thread_id    = cur_q;
    assign bus.thread_valid = active_cur[cur_q];
    assign bus.halted       = halted_q;
    assign bus.all_idle     = ~|active_cur;

endmodule
